// File: rtl/lanzones_mem_pkg.sv
// Shared types and elaboration helpers for the lanzones word memory.
package lanzones_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  // Request kind as carried on ReqWEn.
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  // Ceiling log2; 0 for values of 0 or 1.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned span;
    int unsigned     bits;
    span = 1;
    bits = 0;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // Index width for a structure of the given depth, never narrower than 1.
  function automatic int unsigned idx_w(input longint unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lanzones_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; output word is zero when
// empty. Pointers wrap modulo DEPTH so non-power-of-2 depths work.
module lanzones_rsp_fifo
  import lanzones_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = clog2(DEPTH + 1),
  localparam int unsigned PTR_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only legal when a pop frees the slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign pop_data = empty ? '0 : store[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: rtl/lanzones_mem.sv
// Word memory for the lanzones core: valid/ready request channel, in-order
// read responses after a fixed latency, byte strobes, out-of-range error
// reporting and credit-based flow control sized to the response FIFO.
module lanzones_mem
  import lanzones_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 65536,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned RSP_DEPTH = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ReqVld,
  output logic                       ReqRdy,
  input  logic [ADDR_W-1:0]          ReqAddr,
  input  logic                       ReqWEn,
  input  logic [DATA_W-1:0]          ReqWData,
  input  logic [strb_w(DATA_W)-1:0]  ReqWStrb,
  output logic                       RspVld,
  input  logic                       RspRdy,
  output logic [DATA_W-1:0]          RspData,
  output logic                       RspErr
);

  localparam int unsigned STRB_W = strb_w(DATA_W);
  localparam int unsigned IDX_W  = idx_w(DEPTH);
  localparam int unsigned CNT_W  = clog2(RSP_DEPTH + 1);
  localparam int unsigned ENT_W  = DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_entry_t;

  logic [DATA_W-1:0] mem [DEPTH];

  req_kind_e         kind;
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  outstanding;
  logic              rsp_pop;
  rsp_entry_t        rd_entry;
  rsp_entry_t        fifo_in;
  rsp_entry_t        fifo_out;
  logic              fifo_push;
  logic [CNT_W-1:0]  fifo_count;

  assign kind     = req_kind_e'(ReqWEn);
  assign in_range = (64'(ReqAddr) < 64'(DEPTH));
  assign idx      = ReqAddr[IDX_W-1:0];

  // Credit check is on the registered count, so a pop frees credit next cycle.
  assign ReqRdy = !rst && (outstanding < CNT_W'(RSP_DEPTH));
  assign accept = ReqVld && ReqRdy;
  assign rd_acc = accept && (kind == REQ_READ);
  assign wr_acc = accept && (kind == REQ_WRITE);

  // Byte-lane merge into the array; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (ReqWStrb[b]) begin
          mem[idx][b*BYTE_W +: BYTE_W] <= ReqWData[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read sample: array value before any write of this edge, or an error beat.
  always_comb begin
    rd_entry.data = in_range ? mem[idx] : '0;
    rd_entry.err  = !in_range;
  end

  // The FIFO write itself provides one cycle of latency, so the explicit
  // pipeline holds LATENCY-1 stages and vanishes when LATENCY is 1.
  if (LATENCY == 1) begin : g_lat1
    assign fifo_push = rd_acc;
    assign fifo_in   = rd_entry;
  end else begin : g_pipe
    localparam int unsigned STAGES = LATENCY - 1;

    logic [STAGES-1:0] stage_vld;
    rsp_entry_t        stage_q [STAGES];

    // Fixed-length delay line carrying read results toward the FIFO.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_vld <= '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_vld[0] <= rd_acc;
        stage_q[0]   <= rd_entry;
        for (int unsigned i = 1; i < STAGES; i++) begin
          stage_vld[i] <= stage_vld[i-1];
          stage_q[i]   <= stage_q[i-1];
        end
      end
    end

    assign fifo_push = stage_vld[STAGES-1];
    assign fifo_in   = stage_q[STAGES-1];
  end

  lanzones_rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (rsp_pop),
    .pop_data  (fifo_out),
    .count     (fifo_count)
  );

  assign RspVld  = (fifo_count != '0);
  assign RspData = fifo_out.data;
  assign RspErr  = fifo_out.err;
  assign rsp_pop = RspVld && RspRdy;

  // Credits: reads in the pipeline plus responses waiting in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, rsp_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_credit_bound : assert property (@(posedge clk) disable iff (rst)
    outstanding <= CNT_W'(RSP_DEPTH));

  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (RspVld && !RspRdy) |=> (RspVld && $stable(RspData) && $stable(RspErr)));

endmodule

// File: tb/tb_lanzones_mem.sv
// Randomised scoreboard bench for lanzones_mem: two instances (latency 1 and
// latency 3) share clock and reset; a monitor pops expected beats per instance.
module tb_lanzones_mem;

  localparam int unsigned DEPTH = 65536;
  localparam int unsigned RSPD  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_vld   [2];
  logic        req_rdy   [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_vld   [2];
  logic        rsp_rdy   [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];

  lanzones_mem #(.LATENCY(1), .RSP_DEPTH(RSPD)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .ReqVld(req_vld[0]), .ReqRdy(req_rdy[0]), .ReqAddr(req_addr[0]),
    .ReqWEn(req_wen[0]), .ReqWData(req_wdata[0]), .ReqWStrb(req_wstrb[0]),
    .RspVld(rsp_vld[0]), .RspRdy(rsp_rdy[0]), .RspData(rsp_data[0]), .RspErr(rsp_err[0])
  );

  lanzones_mem #(.LATENCY(3), .RSP_DEPTH(RSPD)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .ReqVld(req_vld[1]), .ReqRdy(req_rdy[1]), .ReqAddr(req_addr[1]),
    .ReqWEn(req_wen[1]), .ReqWData(req_wdata[1]), .ReqWStrb(req_wstrb[1]),
    .RspVld(rsp_vld[1]), .RspRdy(rsp_rdy[1]), .RspData(rsp_data[1]), .RspErr(rsp_err[1])
  );

  // Reference memory window 0..511 per instance; expected beats {data, err}.
  logic [31:0] ref_mem [2][512];
  logic [32:0] exp_q   [2][$];
  logic [32:0] held    [2];
  bit          stalled [2];
  bit          rand_rdy;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_read(input int d, input logic [31:0] addr);
    if (addr >= 32'(DEPTH)) return {32'h0, 1'b1};
    return {ref_mem[d][addr[8:0]], 1'b0};
  endfunction

  task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (addr < 32'(DEPTH)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) ref_mem[d][addr[8:0]][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  // Present one request from posedge+1; leaves ReqVld high on acceptance so
  // requests can go back to back.
  task automatic do_req(input int d, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int budget, output bit ok);
    req_vld[d]   = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = data;
    req_wstrb[d] = strb;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (rand_rdy) rsp_rdy[d] = ($urandom_range(3) != 0);
      if (req_rdy[d]) begin
        if (wen) model_write(d, addr, data, strb);
        else     exp_q[d].push_back(model_read(d, addr));
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) req_vld[d] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      if (rand_rdy) rsp_rdy[d] = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("drain_d%0d", d), 64'(exp_q[d].size()), 64'd0);
  endtask

  // Monitor: sample mid-cycle, compare popped beats, check stall stability.
  task automatic mon(input int d);
    logic [32:0] act;
    logic [32:0] exp;
    act = {rsp_data[d], rsp_err[d]};
    if (rst) begin
      exp_q[d].delete();
      stalled[d] = 1'b0;
      return;
    end
    if (stalled[d])
      check($sformatf("hold_d%0d", d), 64'({rsp_vld[d], act}), 64'({1'b1, held[d]}));
    stalled[d] = 1'b0;
    if (!rsp_vld[d]) begin
      check($sformatf("idle_zero_d%0d", d), 64'(act), 64'd0);
    end else begin
      check($sformatf("rsp_pending_d%0d", d), 64'(exp_q[d].size() != 0), 64'd1);
      if (exp_q[d].size() != 0) begin
        if (rsp_rdy[d]) begin
          exp = exp_q[d].pop_front();
          check($sformatf("rsp_d%0d", d), 64'(act), 64'(exp));
        end else begin
          stalled[d] = 1'b1;
          held[d]    = act;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [31:0] a;
    rst = 1'b1;
    rand_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_vld[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wstrb[d] = '0; rsp_rdy[d] = 1'b1;
      stalled[d] = 1'b0; held[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rdy_d%0d", d), 64'(req_rdy[d]), 64'd0);
      check($sformatf("rst_vld_d%0d", d), 64'(rsp_vld[d]), 64'd0);
      check($sformatf("rst_data_d%0d", d), 64'(rsp_data[d]), 64'd0);
      check($sformatf("rst_err_d%0d", d), 64'(rsp_err[d]), 64'd0);
    end
    rst = 1'b0;
    cycles(1);
    for (int d = 0; d < 2; d++) check($sformatf("rdy_after_rst_d%0d", d), 64'(req_rdy[d]), 64'd1);

    // Fill the reference window so every read below targets written words.
    for (int d = 0; d < 2; d++) begin
      do_req(d, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 4, ok);
      check("init_wr0", 64'(ok), 64'd1);
      for (int i = 0; i < 64; i++) begin
        do_req(d, 1'b1, 32'h100 + 32'(i), $urandom, 4'hF, 4, ok);
        check("init_wr", 64'(ok), 64'd1);
      end
      req_vld[d] = 1'b0;
    end

    // Write then read 0x100 with exact response-latency check.
    for (int d = 0; d < 2; d++) begin
      do_req(d, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 4, ok);
      do_req(d, 1'b0, 32'h100, 32'h0, 4'h0, 4, ok);
      check($sformatf("rd100_acc_d%0d", d), 64'(ok), 64'd1);
      req_vld[d] = 1'b0;
      for (int k = 1; k <= lat(d); k++) begin
        check($sformatf("latency_d%0d_k%0d", d, k), 64'(rsp_vld[d]), 64'(k == lat(d)));
        cycles(1);
      end
      wait_drain(d, 10);
    end

    // Partial strobe merge at 0x101.
    for (int d = 0; d < 2; d++) begin
      do_req(d, 1'b1, 32'h101, 32'h11223344, 4'hF, 4, ok);
      do_req(d, 1'b1, 32'h101, 32'h0000AA00, 4'h2, 4, ok);
      do_req(d, 1'b0, 32'h101, 32'h0, 4'h0, 4, ok);
      req_vld[d] = 1'b0;
      wait_drain(d, 10);
    end

    // Out-of-range reads and a dropped out-of-range write.
    for (int d = 0; d < 2; d++) begin
      do_req(d, 1'b0, 32'(DEPTH), 32'h0, 4'h0, 4, ok);
      do_req(d, 1'b1, 32'(DEPTH), 32'hFFFFFFFF, 4'hF, 4, ok);
      do_req(d, 1'b0, 32'h0, 32'h0, 4'h0, 4, ok);
      do_req(d, 1'b0, 32'hFFFFFFFF, 32'h0, 4'h0, 4, ok);
      req_vld[d] = 1'b0;
      wait_drain(d, 10);
    end

    // Credit exhaustion on the latency-3 instance.
    rsp_rdy[1] = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 32'h100 + 32'(i), 32'h0, 4'h0, 4, ok);
      acc += int'(ok);
    end
    do_req(1, 1'b0, 32'h104, 32'h0, 4'h0, 8, ok);
    check("full_blocks", 64'(ok), 64'd0);
    check("full_accepted", 64'(acc), 64'd4);
    check("full_rdy_low", 64'(req_rdy[1]), 64'd0);
    rsp_rdy[1] = 1'b1;
    do_req(1, 1'b0, 32'h104, 32'h0, 4'h0, 10, ok);
    check("resume_rd4", 64'(ok), 64'd1);
    do_req(1, 1'b0, 32'h105, 32'h0, 4'h0, 10, ok);
    check("resume_rd5", 64'(ok), 64'd1);
    req_vld[1] = 1'b0;
    wait_drain(1, 20);

    // Back-to-back reads with the response side always ready.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        do_req(d, 1'b0, 32'h100 + 32'(i), 32'h0, 4'h0, 1, ok);
        check($sformatf("b2b_rdy_d%0d", d), 64'(ok), 64'd1);
      end
      req_vld[d] = 1'b0;
      cycles(lat(d));
      check($sformatf("b2b_thru_d%0d", d), 64'(exp_q[d].size()), 64'd0);
    end

    // Randomised traffic with random response backpressure.
    rand_rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      repeat (150) begin
        if ($urandom_range(9) == 0) a = 32'(DEPTH) + 32'($urandom_range(1000));
        else                        a = 32'h120 + 32'($urandom_range(31));
        do_req(d, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), 50, ok);
        check("rand_issue", 64'(ok), 64'd1);
        if ($urandom_range(3) == 0) begin
          req_vld[d] = 1'b0;
          cycles(1);
        end
      end
      req_vld[d] = 1'b0;
      wait_drain(d, 200);
    end
    rand_rdy = 1'b0;
    rsp_rdy[0] = 1'b1;
    rsp_rdy[1] = 1'b1;
    cycles(2);

    // Reset with reads in flight; array contents must survive.
    rsp_rdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1, 1'b0, 32'h100 + 32'(i), 32'h0, 4'h0, 4, ok);
    req_vld[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_vld", 64'(rsp_vld[1]), 64'd0);
    check("midrst_rdy", 64'(req_rdy[1]), 64'd0);
    cycles(2);
    rst = 1'b0;
    rsp_rdy[1] = 1'b1;
    cycles(1);
    check("postrst_rdy", 64'(req_rdy[1]), 64'd1);
    cycles(6);
    for (int d = 0; d < 2; d++) begin
      do_req(d, 1'b0, 32'h100, 32'h0, 4'h0, 4, ok);
      req_vld[d] = 1'b0;
      wait_drain(d, 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
